// File: rtl/macc_pipe.sv
// macc_pipe: three-stage pipelined multiply-accumulate unit with a valid
// handshake, global clock enable, signed/unsigned operation, optional
// saturation and a sticky overflow flag that clears on each sload beat.
module macc_pipe #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic             Clk,
  input  logic             aclr_n,
  input  logic             clken,
  input  logic             in_valid,
  input  logic             sload,
  input  logic [A_W-1:0]   dataa,
  input  logic [B_W-1:0]   datab,
  output logic             out_valid,
  output logic [ACC_W-1:0] adder_out,
  output logic             overflow
);

  localparam int P_W = A_W + B_W;

  // Clamp values: unsigned ceiling, signed ceiling and signed floor.
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1 registers
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic             s1_valid_q;
  logic             s1_sload_q;

  // Stage 2 registers
  logic [ACC_W-1:0] prod_q;
  logic             s2_valid_q;
  logic             s2_sload_q;

  // Stage 3 registers (accumulator drives adder_out directly)
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  // Product and its extension to accumulator width
  logic [P_W-1:0]   prod_raw;
  logic [ACC_W-1:0] prod_ext;

  // Accumulate arithmetic
  logic [ACC_W:0]   sum_w;
  logic             same_sign;
  logic             ovf_hit;
  logic [ACC_W-1:0] sat_val;

  // Stage 1: capture operands and tags.
  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      a_q        <= '0;
      b_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_sload_q <= 1'b0;
    end else if (clken) begin
      a_q        <= dataa;
      b_q        <= datab;
      s1_valid_q <= in_valid;
      s1_sload_q <= sload;
    end
  end

  // Operands are widened to the full product width before multiplying so
  // the low P_W bits of the product are exact in both modes.
  generate
    if (SIGNED != 0) begin : g_signed
      assign prod_raw = P_W'($signed(a_q)) * P_W'($signed(b_q));
      assign prod_ext = ACC_W'($signed(prod_raw));
    end else begin : g_unsigned
      assign prod_raw = P_W'(a_q) * P_W'(b_q);
      assign prod_ext = ACC_W'(prod_raw);
    end
  endgenerate

  // Stage 2: register the extended product and forward the tags.
  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      prod_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_sload_q <= 1'b0;
    end else if (clken) begin
      prod_q     <= prod_ext;
      s2_valid_q <= s1_valid_q;
      s2_sload_q <= s1_sload_q;
    end
  end

  // Stage 3 next state: load, accumulate with overflow detection, or hold
  // on a bubble. Clamp direction follows the sign of the incoming product.
  always_comb begin
    sum_w     = {1'b0, acc_q} + {1'b0, prod_q};
    same_sign = (acc_q[ACC_W-1] == prod_q[ACC_W-1]);
    if (SIGNED != 0) begin
      ovf_hit = same_sign && (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
      sat_val = prod_q[ACC_W-1] ? SMIN : SMAX;
    end else begin
      ovf_hit = sum_w[ACC_W];
      sat_val = UMAX;
    end

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = s2_valid_q;

    if (s2_valid_q) begin
      if (s2_sload_q) begin
        acc_d = prod_q;
        ovf_d = 1'b0;
      end else if (ovf_hit) begin
        acc_d = (SATURATE != 0) ? sat_val : sum_w[ACC_W-1:0];
        ovf_d = 1'b1;
      end else begin
        acc_d = sum_w[ACC_W-1:0];
      end
    end
  end

  // Stage 3 registers: accumulator, output valid and sticky overflow.
  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clken) begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign adder_out = acc_q;
  assign out_valid = out_valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_macc_pipe.sv
// tb_macc_pipe: drives four macc_pipe configurations with shared stimulus
// and checks each against a beat-level arithmetic reference model.
module tb_macc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aclr_n;
  logic       clken;
  logic       in_valid;
  logic       sload;
  logic [7:0] dataa;
  logic [7:0] datab;

  logic        ov_o [4];
  logic        ovf_o [4];
  logic [23:0] ao_def;
  logic [15:0] ao_u16s;
  logic [15:0] ao_u16w;
  logic [15:0] ao_s16;

  macc_pipe #(.A_W(8), .B_W(8), .ACC_W(24), .SIGNED(0), .SATURATE(1)) u_def (
    .Clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .sload(sload),
    .dataa(dataa), .datab(datab), .out_valid(ov_o[0]), .adder_out(ao_def), .overflow(ovf_o[0]));

  macc_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1)) u_u16s (
    .Clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .sload(sload),
    .dataa(dataa), .datab(datab), .out_valid(ov_o[1]), .adder_out(ao_u16s), .overflow(ovf_o[1]));

  macc_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(0)) u_u16w (
    .Clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .sload(sload),
    .dataa(dataa), .datab(datab), .out_valid(ov_o[2]), .adder_out(ao_u16w), .overflow(ovf_o[2]));

  macc_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1)) u_s16 (
    .Clk(clk), .aclr_n(aclr_n), .clken(clken), .in_valid(in_valid), .sload(sload),
    .dataa(dataa), .datab(datab), .out_valid(ov_o[3]), .adder_out(ao_s16), .overflow(ovf_o[3]));

  // Reference model: beats wait in a latency line of enabled edges, then
  // are applied with true-valued integer arithmetic and range clamping.
  typedef struct packed {
    logic       v;
    logic       sl;
    logic [7:0] a;
    logic [7:0] b;
  } beat_t;

  beat_t  dly[$];
  longint acc_m [4];
  bit     ovf_m [4];
  bit     ov_m;
  int     accw [4] = '{24, 16, 16, 16};
  bit     sgn  [4] = '{0, 0, 0, 1};
  bit     sat  [4] = '{1, 1, 0, 1};

  int n_vec = 0;
  int n_err = 0;

  function automatic longint obs_ao(int k);
    case (k)
      0:       return longint'(ao_def);
      1:       return longint'(ao_u16s);
      2:       return longint'(ao_u16w);
      default: return longint'(ao_s16);
    endcase
  endfunction

  function automatic void model_reset();
    beat_t z;
    z = '0;
    for (int k = 0; k < 4; k++) begin
      acc_m[k] = 0;
      ovf_m[k] = 1'b0;
    end
    ov_m = 1'b0;
    dly.delete();
    dly.push_back(z);
    dly.push_back(z);
  endfunction

  function automatic void apply(int k, beat_t f);
    longint m, p, s, hi, lo;
    m = longint'(1) << accw[k];
    if (sgn[k]) begin
      p  = longint'($signed(f.a)) * longint'($signed(f.b));
      hi = m / 2 - 1;
      lo = -(m / 2);
    end else begin
      p  = longint'(f.a) * longint'(f.b);
      hi = m - 1;
      lo = 0;
    end
    if (f.sl) begin
      acc_m[k] = p;
      ovf_m[k] = 1'b0;
    end else begin
      s = acc_m[k] + p;
      if (s > hi) begin
        ovf_m[k] = 1'b1;
        acc_m[k] = sat[k] ? hi : s - m;
      end else if (s < lo) begin
        ovf_m[k] = 1'b1;
        acc_m[k] = sat[k] ? lo : s + m;
      end else begin
        acc_m[k] = s;
      end
    end
  endfunction

  function automatic void model_edge(logic v, logic sl, logic [7:0] a, logic [7:0] b);
    beat_t n, f;
    n.v = v; n.sl = sl; n.a = a; n.b = b;
    dly.push_back(n);
    f = dly.pop_front();
    ov_m = f.v;
    if (f.v) begin
      for (int k = 0; k < 4; k++) apply(k, f);
    end
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    longint mask;
    for (int k = 0; k < 4; k++) begin
      mask = (longint'(1) << accw[k]) - 1;
      chk($sformatf("u%0d out_valid", k), longint'(ov_o[k]), longint'(ov_m));
      chk($sformatf("u%0d adder_out", k), obs_ao(k), acc_m[k] & mask);
      chk($sformatf("u%0d overflow", k), longint'(ovf_o[k]), longint'(ovf_m[k]));
    end
  endtask

  task automatic step(input logic en, input logic v, input logic sl,
                      input logic [7:0] a, input logic [7:0] b);
    clken = en; in_valid = v; sload = sl; dataa = a; datab = b;
    @(posedge clk);
    if (en) model_edge(v, sl, a, b);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  // Reset is asserted between clock edges and checked before any edge.
  task automatic do_reset();
    #2 aclr_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    aclr_n = 1'b1;
  endtask

  initial begin
    aclr_n = 1'b1; clken = 1'b0; in_valid = 1'b0; sload = 1'b0;
    dataa = 8'd0; datab = 8'd0;
    do_reset();

    // Basic unsigned accumulate chain with 3-edge latency.
    step(1, 1, 1, 8'd0, 8'd0);
    chk("t1 latency e1", longint'(ov_o[0]), 64'd0);
    step(1, 1, 0, 8'd1, 8'd1);
    chk("t1 latency e2", longint'(ov_o[0]), 64'd0);
    step(1, 1, 0, 8'd1, 8'd10);
    chk("t1 first out", longint'(ov_o[0]), 64'd1);
    step(1, 1, 0, 8'd10, 8'd1);
    step(1, 1, 0, 8'd9, 8'd8);
    idle(2);
    chk("t1 result", longint'(ao_def), 64'd93);

    // Reset with two beats in flight; they must never surface.
    step(1, 1, 0, 8'd5, 8'd5);
    step(1, 1, 0, 8'd6, 8'd6);
    do_reset();
    step(1, 1, 0, 8'd3, 8'd4);
    idle(3);
    chk("t6 after reset", longint'(ao_def), 64'd12);

    // Unsigned 16-bit saturate vs wrap.
    do_reset();
    step(1, 1, 1, 8'd255, 8'd255);
    step(1, 1, 0, 8'd255, 8'd255);
    idle(2);
    chk("t2 sat value", longint'(ao_u16s), 64'd65535);
    chk("t2 sat ovf", longint'(ovf_o[1]), 64'd1);
    chk("t3 wrap value", longint'(ao_u16w), 64'd64514);
    step(1, 1, 1, 8'd2, 8'd3);
    idle(2);
    chk("t2 reload", longint'(ao_u16s), 64'd6);
    chk("t2 reload ovf", longint'(ovf_o[1]), 64'd0);

    // Signed 16-bit: load, negative add, positive clamp, then recovery.
    do_reset();
    step(1, 1, 1, 8'h80, 8'h80);
    step(1, 1, 0, 8'hFD, 8'h05);
    idle(2);
    chk("t4 signed sum", longint'(ao_s16), 64'd16369);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8'd127, 8'd127);
    idle(2);
    chk("t4 clamp", longint'(ao_s16), 64'd32767);
    chk("t4 clamp ovf", longint'(ovf_o[3]), 64'd1);
    step(1, 1, 0, 8'h80, 8'd127);
    idle(2);

    // Bubbles and clock-enable stalls.
    do_reset();
    step(1, 1, 1, 8'd2, 8'd3);
    step(1, 0, 0, 8'd9, 8'd9);
    step(1, 1, 0, 8'd4, 8'd5);
    step(0, 1, 1, 8'd7, 8'd7);
    step(0, 0, 0, 8'd1, 8'd1);
    chk("t5 stall hold", longint'(ao_def), 64'd6);
    step(1, 0, 0, 8'd0, 8'd0);
    chk("t5 bubble gap", longint'(ov_o[0]), 64'd0);
    step(1, 0, 0, 8'd0, 8'd0);
    chk("t5 result", longint'(ao_def), 64'd26);
    idle(2);

    // Randomized traffic with occasional stalls, loads and resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/macc_pipe.md
Name: macc_pipe

Overview:
Parametrised, pipelined multiply-accumulate unit. It is the next generation of the 8x8 unsigned altmult-accumulate block in FunctionalUnits/macc.
- Adds configurable operand/accumulator widths, signed mode, optional saturation and a sticky overflow flag.
- Adds a per-beat valid handshake with bubble support.
- Feeds downstream dot-product/filter datapaths that consume one accumulated result per valid input beat.

Parameters:
A_W, 8, dataa width in bits.
B_W, 8, datab width in bits.
ACC_W, 24, accumulator/output width in bits; must be >= A_W+B_W.
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and accumulator.
SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
Clk  input  1  clock, rising edge.
aclr_n  input  1  asynchronous active-low reset.
clken  input  1  global clock enable; 0 freezes every pipeline register.
in_valid  input  1  input beat qualifier.
sload  input  1  with in_valid: start a new accumulation (acc = product).
dataa  input  A_W  multiplicand.
datab  input  B_W  multiplier.
out_valid  output  1  adder_out updated by a valid beat this cycle.
adder_out  output  ACC_W  accumulator value.
overflow  output  1  sticky overflow since the last sload beat.

Behaviour:
- Reset (aclr_n=0, asynchronous): all stage registers, the accumulator, adder_out, out_valid and overflow go to 0. This applies immediately, including mid-pipeline; in-flight beats are discarded. After deassertion, the first beat without sload accumulates onto 0.
- Pipeline: 3 stages, each advancing only when clken=1.
  - S1 registers dataa, datab, sload and in_valid.
  - S2 registers the product, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_W, plus the valid and sload tags.
  - S3 updates the accumulator, adder_out, out_valid and overflow.
- Latency: a beat sampled at clken edge N appears on adder_out/out_valid after clken edge N+2, i.e. 3 enabled edges.
- clken=0: no register changes. out_valid, adder_out and overflow hold their values; out_valid is not forced low.
- in_valid=0 (bubble): travels down the pipe. At S3 the accumulator is unchanged and out_valid=0 for that enabled cycle.
- S3 valid beat with sload=1: acc = product; overflow = 0 (the product alone cannot overflow, given ACC_W >= A_W+B_W).
- S3 valid beat with sload=0: sum = acc + product, computed at ACC_W+1 bits.
  - Unsigned: overflow when the carry-out is set.
  - Signed: overflow when both operands have the same sign and the result sign differs.
  - On overflow with SATURATE=1: acc clamps to 2^ACC_W-1 (unsigned), or to +2^(ACC_W-1)-1 / -2^(ACC_W-1) (signed), following the product's sign.
  - On overflow with SATURATE=0: acc takes the wrapped sum.
  - Either way overflow is set to 1 and stays sticky until the next sload beat.
- Saturated hold: once clamped, further same-direction products keep acc at the limit. An opposite-sign product (signed mode) accumulates normally from the limit value.
- adder_out is the accumulator register itself; there is no combinational path from the inputs.
- out_valid is 1 for exactly one enabled cycle per valid input beat and follows the input valid pattern delayed by 3 enabled edges.
- Back-to-back valid beats every cycle are supported (throughput 1/cycle). There is no backpressure input; the consumer must accept every out_valid.
- sload with in_valid=0 is ignored.

Test Plan:
1. Defaults (8/8/24, unsigned). Beats (sload=1, 0,0), (1,1), (1,10), (10,1), (9,8) on consecutive cycles -> adder_out 0, 1, 11, 21, 93 with out_valid=1 on 5 consecutive cycles starting 3 edges after the first beat; overflow=0.
2. ACC_W=16, SATURATE=1, unsigned. (sload, 255,255) then (255,255) -> adder_out 65025, then 65535 with overflow=1. A next sload beat (2,3) -> adder_out 6, overflow=0.
3. Same as test 2 with SATURATE=0 -> second result 64514 (130050 mod 65536), overflow=1.
4. SIGNED=1, ACC_W=16. (sload, -128,-128) then (-3,5) -> adder_out 16384, then 16369. Then ACC_W=16 with repeated (sload=0, 127,127) beats until clamp -> holds 32767, overflow=1.
5. Bubbles and clken. Beats (2,3) sload, bubble, (4,5), with clken low 2 cycles mid-stream -> outputs 6 then 26. out_valid shows the bubble gap. Registers hold during clken=0, and total latency equals 3 enabled edges.
6. Reset mid-operation. Accumulate to 93 as in test 1, pulse aclr_n low asynchronously between edges with 2 beats in flight -> adder_out, out_valid and overflow go to 0 immediately; in-flight beats never appear. The next beat (3,4) without sload -> 12.
